// File: rtl/word_assembler_pkg.sv
// Shared defaults and types for the word assembler: the project-wide word/lane
// widths and timeout, plus the fill-state encoding.
package word_assembler_pkg;

    localparam int WA_DEF_OW      = 32;
    localparam int WA_DEF_USBDW   = 8;
    localparam int WA_DEF_TIMEOUT = 1024;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } wa_state_e;

    function automatic int lanes_per_word(input int ow, input int usbdw);
        return ow / usbdw;
    endfunction

endpackage

// File: rtl/word_assembler_if.sv
// Lane-in / word-out handshake bundle for the word assembler.
// slave is the assembler's view, master the upstream/downstream environment.
interface word_assembler_if
    import word_assembler_pkg::*;
#(
    parameter int OW    = WA_DEF_OW,
    parameter int USBDW = WA_DEF_USBDW
) ();

    logic [USBDW-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             flush_i;
    logic [OW-1:0]    data_o;
    logic             valid_o;
    logic             ready_i;
    logic             err_o;

    modport slave (
        input  data_i, valid_i, flush_i, ready_i,
        output ready_o, data_o, valid_o, err_o
    );

    modport master (
        output data_i, valid_i, flush_i, ready_i,
        input  ready_o, data_o, valid_o, err_o
    );

endinterface

// File: rtl/word_assembler.sv
// Packs N = OW/USBDW byte lanes, MSB-first, into one OW-bit word with a held output stage.
// Define WORD_ASSEMBLER_TIMEOUT_EN to discard stale partial words after TIMEOUT idle cycles.
module word_assembler
    import word_assembler_pkg::*;
#(
    parameter int OW      = WA_DEF_OW,
    parameter int USBDW   = WA_DEF_USBDW,
    parameter int TIMEOUT = WA_DEF_TIMEOUT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    word_assembler_if.slave bus
);

    localparam int N  = lanes_per_word(OW, USBDW);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_r;
    logic [OW-1:0] acc_r;
    logic [OW-1:0] data_r;
    logic          valid_r;
    logic          err_r;
    wa_state_e     st_r;

    logic [OW-1:0] word_s;
    logic          ready_s;
    logic          accept_s;
    logic          last_s;
    logic          consume_s;
    logic          timeout_s;

    // Back-pressure only when the last lane would overwrite a word still being held.
    always_comb begin
        ready_s = !(bus.flush_i || ((cnt_r == LAST) && valid_r && !bus.ready_i));
    end

    assign accept_s  = bus.valid_i && ready_s;
    assign last_s    = accept_s && (cnt_r == LAST);
    assign consume_s = valid_r && bus.ready_i;

    // Accumulator with the incoming lane merged at its MSB-first slot.
    always_comb begin
        word_s = acc_r;
        for (int k = 0; k < N; k++) begin
            word_s[OW-1-k*USBDW -: USBDW] = (cnt_r == CW'(k)) ? bus.data_i
                                                             : acc_r[OW-1-k*USBDW -: USBDW];
        end
    end

`ifdef WORD_ASSEMBLER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_r;

    assign timeout_s = (st_r == ST_FILL) && !accept_s && !bus.flush_i &&
                       (timer_r == TW'(TIMEOUT - 1));

    // Idle-cycle timer, only running while a partial word is pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_r <= '0;
        end else if (accept_s || bus.flush_i || timeout_s || (st_r == ST_IDLE)) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + TW'(1);
        end
    end
`else
    logic unused_cfg_s;

    assign timeout_s    = 1'b0;
    assign unused_cfg_s = (st_r == ST_FILL) && (TIMEOUT > 0);
`endif

    // Lane counter / fill state, accumulation and registered output stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r   <= '0;
            acc_r   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            st_r    <= ST_IDLE;
        end else begin
            err_r <= timeout_s;

            if (last_s) begin
                data_r  <= word_s;
                valid_r <= 1'b1;
            end else if (consume_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end

            if (bus.flush_i || timeout_s || last_s) begin
                cnt_r <= '0;
                acc_r <= '0;
                st_r  <= ST_IDLE;
            end else if (accept_s) begin
                cnt_r <= cnt_r + CW'(1);
                acc_r <= word_s;
                st_r  <= ST_FILL;
            end else begin
                cnt_r <= cnt_r;
                acc_r <= acc_r;
                st_r  <= st_r;
            end
        end
    end

    assign bus.ready_o = ready_s;
    assign bus.data_o  = data_r;
    assign bus.valid_o = valid_r;
    assign bus.err_o   = err_r;

endmodule

// File: tb/tb_word_assembler.sv
// Directed bench for word_assembler (OW=32, USBDW=8, TIMEOUT=16) with a lane-queue
// reference model checked every cycle plus literal word expectations per scenario.
module tb_word_assembler;

    localparam int OW    = 32;
    localparam int USBDW = 8;
    localparam int N     = OW / USBDW;
    localparam int TO    = 16;
`ifdef WORD_ASSEMBLER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    word_assembler_if #(.OW(OW), .USBDW(USBDW)) bus ();

    word_assembler #(.OW(OW), .USBDW(USBDW), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [USBDW-1:0] part[$];
    logic [OW-1:0]    out_words[$];
    logic             mvalid;
    logic [OW-1:0]    mdata;
    logic             merr;
    int               idle_cnt;
    bit               armed = 1'b0;
    int               err_pulses = 0;
    int               stalls = 0;
    logic             m_ready;
    logic             m_acc;
    logic             m_cons;
    logic [OW-1:0]    m_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: lanes queue up, every N-th accepted lane emits the packed word.
    always @(negedge clk) begin
        m_ready = !(bus.flush_i || ((part.size() == N - 1) && mvalid && !bus.ready_i));
        if (armed) begin
            chk("ready_o", {31'd0, bus.ready_o}, {31'd0, m_ready});
            chk("valid_o", {31'd0, bus.valid_o}, {31'd0, mvalid});
            chk("data_o", bus.data_o, mdata);
            chk("err_o", {31'd0, bus.err_o}, {31'd0, merr});
            if (bus.err_o === 1'b1) err_pulses++;
        end
        m_acc  = bus.valid_i && m_ready;
        m_cons = mvalid && bus.ready_i;
        if (rst) begin
            part.delete();
            mvalid   = 1'b0;
            mdata    = '0;
            merr     = 1'b0;
            idle_cnt = 0;
            armed    = 1'b1;
        end else if (armed) begin
            merr = 1'b0;
            if (m_cons) begin
                out_words.push_back(mdata);
                mvalid = 1'b0;
            end
            if (bus.flush_i) begin
                part.delete();
                idle_cnt = 0;
            end else if (m_acc) begin
                part.push_back(bus.data_i);
                idle_cnt = 0;
                if (part.size() == N) begin
                    m_w = '0;
                    foreach (part[k]) m_w = (m_w << USBDW) | OW'(part[k]);
                    mdata  = m_w;
                    mvalid = 1'b1;
                    part.delete();
                end
            end else if (part.size() > 0) begin
                idle_cnt++;
                if (TO_EN && idle_cnt == TO) begin
                    part.delete();
                    idle_cnt = 0;
                    merr     = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bit ok;
        bit done;
        done = 1'b0;
        bus.data_i  = d;
        bus.valid_i = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            #2;
            ok = bus.ready_o;
            cyc();
            if (ok) done = 1'b1;
            else stalls++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: lane %h never accepted", d);
        end
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic check_words(input string nm, input int n,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2);
        chk({nm, "_count"}, out_words.size(), n);
        if (n > 0 && out_words.size() > 0) chk({nm, "_w0"}, out_words[0], w0);
        if (n > 1 && out_words.size() > 1) chk({nm, "_w1"}, out_words[1], w1);
        if (n > 2 && out_words.size() > 2) chk({nm, "_w2"}, out_words[2], w2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rst_data", bus.data_o, 32'h0000_0000);
        chk("rst_err", {31'd0, bus.err_o}, 32'd0);
        chk("rst_ready", {31'd0, bus.ready_o}, 32'd1);

        out_words.delete();
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        bus.valid_i = 1'b0;
        #1;
        chk("beef_valid", {31'd0, bus.valid_o}, 32'd1);
        chk("beef_data", bus.data_o, 32'hDEAD_BEEF);
        cyc();
        chk("beef_one_cycle", {31'd0, bus.valid_o}, 32'd0);
        idle(1);
        check_words("beef", 1, 32'hDEAD_BEEF, 32'h0, 32'h0);

        stalls = 0;
        out_words.delete();
        for (int i = 0; i < 12; i++) send(8'(i));
        idle(2);
        chk("stream_stalls", stalls, 32'd0);
        check_words("stream", 3, 32'h0001_0203, 32'h0405_0607, 32'h0809_0A0B);

        bus.ready_i = 1'b0;
        out_words.delete();
        send(8'h10); send(8'h11); send(8'h12); send(8'h13);
        send(8'h20); send(8'h21); send(8'h22);
        bus.data_i  = 8'h23;
        bus.valid_i = 1'b1;
        cyc();
        cyc();
        #1;
        chk("stall_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("stall_data", bus.data_o, 32'h1011_1213);
        chk("stall_valid", {31'd0, bus.valid_o}, 32'd1);
        bus.ready_i = 1'b1;
        #1;
        chk("release_ready", {31'd0, bus.ready_o}, 32'd1);
        cyc();
        chk("nobubble_valid", {31'd0, bus.valid_o}, 32'd1);
        chk("nobubble_data", bus.data_o, 32'h2021_2223);
        idle(2);
        check_words("stall", 2, 32'h1011_1213, 32'h2021_2223, 32'h0);

        out_words.delete();
        send(8'h11); send(8'h22);
        bus.data_i  = 8'h33;
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        #1;
        chk("flush_ready", {31'd0, bus.ready_o}, 32'd0);
        cyc();
        bus.flush_i = 1'b0;
        send(8'h44); send(8'h45); send(8'h46); send(8'h47);
        idle(2);
        check_words("flush", 1, 32'h4445_4647, 32'h0, 32'h0);

        err_pulses = 0;
        out_words.delete();
        send(8'hAA); send(8'hBB);
        idle(TO);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(2);
        chk("timeout_pulses", err_pulses, TO_EN ? 32'd1 : 32'd0);
        check_words("timeout", 1, TO_EN ? 32'h0102_0304 : 32'hAABB_0102, 32'h0, 32'h0);
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i = 1'b0;

        bus.ready_i = 1'b0;
        out_words.delete();
        send(8'h50); send(8'h51); send(8'h52); send(8'h53);
        send(8'h60); send(8'h61);
        bus.valid_i = 1'b0;
        rst = 1'b1;
        cyc();
        chk("midrst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("midrst_data", bus.data_o, 32'h0000_0000);
        rst = 1'b0;
        bus.ready_i = 1'b1;
        send(8'h70); send(8'h71); send(8'h72); send(8'h73);
        idle(2);
        check_words("midrst", 1, 32'h7071_7273, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/word_assembler.md
WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 SHALL take parameter OW, default from project defaults in fmcw_defines.vh: output word width in bits.
REQ-002 SHALL take parameter USBDW, default from project defaults: input byte-lane width in bits; OW SHALL be an integer multiple N=OW/USBDW, N>=2.
REQ-003 SHALL take parameter TIMEOUT, default 1024: idle cycles before a partial word is discarded (used only under REQ-024).
REQ-004 clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 data_i  in  USBDW  incoming lane from USB receive path.
REQ-007 valid_i  in  1  data_i valid this cycle.
REQ-008 ready_o  out  1  lane accepted when valid_i && ready_o.
REQ-009 flush_i  in  1  discard any partial word (resync).
REQ-010 data_o  out  OW  assembled word.
REQ-011 valid_o  out  1  data_o valid.
REQ-012 ready_i  in  1  downstream accepts when valid_o && ready_i.
REQ-013 err_o  out  1  one-cycle pulse on timeout discard (0 when REQ-024 macro absent).

Function
REQ-014 Lane order SHALL be MSB-first: k-th accepted lane of a word (k=0..N-1) lands in data_o[OW-1-k*USBDW -: USBDW], the inverse of the transmit-side split.
REQ-015 Lane counter cnt (0..N-1) SHALL define states: IDLE (cnt=0, no partial word), FILL (cnt 1..N-1); each accepted lane increments cnt; acceptance at cnt=N-1 wraps cnt to 0 and commits the word.
REQ-016 Partial lanes SHALL be held in an accumulation register separate from the output register.
REQ-017 Committed word SHALL appear on data_o with valid_o=1 on the cycle after the final lane is accepted (latency 1).
REQ-018 ready_o SHALL be 0 only when cnt=N-1 && valid_o && !ready_i, or when flush_i=1; otherwise 1 (combinational).
REQ-019 Final lane accepted in the same cycle the held word is consumed (valid_o && ready_i) SHALL load the new word with valid_o staying 1; no bubble, no loss.
REQ-020 While valid_o && !ready_i, data_o and valid_o SHALL hold stable.
REQ-021 flush_i=1 SHALL clear cnt and accumulation next cycle; a lane presented in the flush cycle SHALL be dropped (ready_o=0); output register unaffected.
REQ-022 No word SHALL ever be emitted containing lanes from before a flush, reset or timeout.

Reset
REQ-023 rst_i SHALL, next edge, set cnt=0, accumulation=0, data_o=0, valid_o=0, err_o=0, idle timer=0; reset mid-word discards partial lanes; reset dominates flush_i and all traffic.

Configuration
REQ-024 With WORD_ASSEMBLER_TIMEOUT_EN defined: in FILL, an idle timer counts cycles without an accepted lane; on reaching TIMEOUT, cnt and accumulation clear and err_o pulses 1 cycle; timer resets on any accepted lane, flush or entry to IDLE. Without macro: no timer, partial words held indefinitely, err_o tied 0.

Structure
REQ-025 Default OW/USBDW SHALL come from the shared fmcw_defines.vh parameter set; derived N and lane-counter width SHALL be localparams in the module; TIMEOUT default SHALL be added to the shared defines.
REQ-026 Single flat module; no sub-module (timeout counter inline under the macro).

Verification (bench OW=32, USBDW=8, TIMEOUT=16)
REQ-027 Lanes 0xDE,0xAD,0xBE,0xEF back-to-back, ready_i=1 -> data_o=0xDEADBEEF, valid_o=1 one cycle after 0xEF, for one cycle.
REQ-028 Continuous lanes 0x00..0x0B, ready_i=1 -> words 0x00010203, 0x04050607, 0x08090A0B on consecutive 4-cycle boundaries, ready_o always 1.
REQ-029 ready_i=0 with word held, 4 further lanes offered -> 3 accepted, 4th stalls (ready_o=0), data_o stable; ready_i=1 -> held word out, new word valid next cycle.
REQ-030 Lanes 0x11,0x22 then flush_i=1 with 0x33 presented, then 0x44..0x47 -> only 0x44454647 emitted.
REQ-031 Macro on: lanes 0xAA,0xBB then 16 idle cycles -> err_o pulses once, next 4 lanes 0x01..0x04 -> 0x01020304; macro off: same stimulus -> 0xAABB0102, err_o=0.
REQ-032 rst_i asserted after 2 lanes with a word held -> valid_o=0, data_o=0 next cycle; next 4 lanes form a clean word.
